// File: rtl/sram_1r1w_init_ext.sv
// rtl/sram_1r1w_init_ext.sv - 1R1W masked-write SRAM model with post-reset init sweep
// Optional same-address write bypass on reads: `define SRAM_WRITE_BYPASS_EN
module sram_1r1w_init_ext #(
    parameter int                DATA_W       = 528,
    parameter int                MASK_LANES   = 16,
    parameter int                LANE_W       = 33,
    parameter int                DEPTH        = 1024,
    parameter int                ADDR_W       = 10,
    parameter int                READ_LATENCY = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  init_done,
    input  logic                  R0_en,
    input  logic [ADDR_W-1:0]     R0_addr,
    output logic [DATA_W-1:0]     R0_rdata,
    output logic                  R0_valid,
    input  logic                  W0_en,
    input  logic [ADDR_W-1:0]     W0_addr,
    input  logic [MASK_LANES-1:0] W0_mask,
    input  logic [DATA_W-1:0]     W0_data
);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    // Extra bit keeps the range compare correct when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic               ready;
    logic               wr_ok;
    logic               rd_fire;
    logic               rd_in_range;
    logic [DATA_W-1:0]  rd_row;
    logic               s1_valid;
    logic [DATA_W-1:0]  s1_data;

    logic [DATA_W-1:0]  ram [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ROW) begin
                state_d = ST_READY;
                cnt_d   = '0;
            end
        end
    end

    assign ready       = (state_q == ST_READY);
    assign init_done   = ready;
    assign wr_ok       = ready && W0_en && ({1'b0, W0_addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, R0_addr} < DEPTH_X);
    assign rd_fire     = ready && R0_en;

    // Array itself has no reset; the sweep is what clears it.
    always_ff @(posedge clock) begin
        if (state_q == ST_INIT) begin
            ram[cnt_q] <= INIT_VALUE;
        end else if (wr_ok) begin
            for (int i = 0; i < MASK_LANES; i++) begin
                if (W0_mask[i]) begin
                    ram[W0_addr][i*LANE_W +: LANE_W] <= W0_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    always_comb begin
        rd_row = '0;
        if (rd_in_range) begin
            rd_row = ram[R0_addr];
`ifdef SRAM_WRITE_BYPASS_EN
            if (wr_ok && (W0_addr == R0_addr)) begin
                for (int i = 0; i < MASK_LANES; i++) begin
                    if (W0_mask[i]) begin
                        rd_row[i*LANE_W +: LANE_W] = W0_data[i*LANE_W +: LANE_W];
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_fire;
            if (rd_fire) begin
                s1_data <= rd_row;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              s2_valid;
            logic [DATA_W-1:0] s2_data;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign R0_valid = s2_valid;
            assign R0_rdata = s2_data;
        end else begin : g_lat1
            assign R0_valid = s1_valid;
            assign R0_rdata = s1_data;
        end
    endgenerate

endmodule
